piece_queue: RTL and testbench
==============================

# piece_queue

Converts the 6-bit random words from the PRBS generator into tetromino IDs 0..6 with no modulo bias. Holds them in a small FIFO so the game controller can take the current piece and show a preview of the next one. Sits between the PRBS generator (producer) and the game-logic FSM (consumer). Refills itself in the background so a piece is ready whenever the controller asks.

## Interface
- DEPTH, 4, queue entries; legal range 2..8.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rnd_data  in  6  random word from PRBS; qualified by rnd_valid.
- rnd_valid  in  1  one-cycle strobe: rnd_data is a new sample.
- pop  in  1  consumer takes head entry this cycle.
- head_piece  out  3  piece ID at queue head (0..6).
- head_valid  out  1  head_piece is valid (count ≥ 1).
- preview_piece  out  3  piece ID of second entry.
- preview_valid  out  1  preview_piece is valid (count ≥ 2).
- count  out  4  number of occupied entries, 0..DEPTH.
- underflow  out  1  sticky flag: pop seen while empty; cleared only by rst.

## Operation
- Mapping: a sample v = 63 is rejected and nothing is written. Any v in 0..62 maps to piece = v mod 7, which is uniform because 63 = 9·7.
- Mod-7 is computed in 6-bit unsigned arithmetic. The result is 3 bits, and the value 7 is never produced.
- Accept condition: rnd_valid & v≠63 & not full, gated by the no-repeat rule if compiled in.
- A sample is discarded if the queue is full or v = 63. Discarded samples do not change any state.
- The queue is a circular buffer with wr_ptr, rd_ptr (mod DEPTH) and count. head is mem[rd_ptr] and preview is mem[(rd_ptr+1) mod DEPTH].
- pop with count ≥ 1 advances rd_ptr and decrements count.
- pop with count = 0 is ignored and sets underflow.
- Simultaneous accept and pop:
  - count unchanged, both pointers advance.
  - This is legal even when full: the pop frees the slot in the same edge, so the sample is accepted.
- Data path:
  - last_piece register holds the ID of the most recently accepted piece; reset value is 7 ("none").
  - Updated on every accept.
- Data-path state: a sample pass through IDLE→ACCEPT is purely per-cycle. No multi-cycle FSM exists outside the no-repeat option.

## Timing
- Reset (async assert, sync deassert by system): count=0, pointers=0, head_piece=0, head_valid=0, preview_piece=0, preview_valid=0, underflow=0, last_piece=7.
- Write latency: a sample accepted at edge n is visible on head_piece/head_valid (if the queue was empty) or preview (if count was 1) after edge n.
- Outputs are derived combinationally from registered state. There is no path from rnd_data or pop to any output.
- pop at edge n: the new head appears after edge n.
- Throughput: at most one accept per cycle. At the PRBS rate of one sample per 8 cycles, an empty DEPTH=4 queue fills in 32 cycles absent rejections.
- rst asserted mid-operation clears the queue immediately. Samples arriving during rst are lost.

## Configuration
- PIECE_NOREPEAT_EN defined: anti-repeat reroll.
  - A candidate piece equal to last_piece is discarded once, and a 1-bit reroll_used flag is set.
  - The next candidate is accepted unconditionally and clears reroll_used.
  - Any accept of a non-equal piece also clears reroll_used.
  - reroll_used resets to 0.
  - Full and v=63 discards do not touch reroll_used.
- Not defined: every valid, non-63 sample is accepted when not full, and reroll_used logic is absent.

## Test plan
- Reset then push v=5, v=62, v=14 (8 cycles apart) -> count=3, head=5, preview=6, after two pops head=0, count=1.
- Push v=63 into empty queue -> head_valid stays 0, count=0. Then v=13 -> head=6.
- Fill DEPTH=4 with v=0,1,2,3, push v=4 -> discarded, count=4. Same cycle pop+push v=4 -> count=4, head=1, tail=4.
- Pop on empty queue -> count stays 0, underflow=1 until rst. Assert rst mid-fill (count=2) -> all outputs 0 the same cycle.
- With PIECE_NOREPEAT_EN: push v=3, v=10, v=17 -> first accepted (3), 10 (=3) rejected, 17 (=3) accepted; count=2, head=3, preview=3.
- Without PIECE_NOREPEAT_EN: same stimulus -> count=3, all entries 3.

Source files
------------

// File: rtl/piece_queue.sv
// Tetromino piece queue: unbiased 6-bit -> 0..6 mapping feeding a small circular FIFO.
// Optional anti-repeat reroll when compiled with PIECE_NOREPEAT_EN.
module piece_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] rnd_data,
  input  logic       rnd_valid,
  input  logic       pop,
  output logic [2:0] head_piece,
  output logic       head_valid,
  output logic [2:0] preview_piece,
  output logic       preview_valid,
  output logic [3:0] count,
  output logic       underflow
);

  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] PtrMax = PtrW'(DEPTH - 1);
  localparam logic [3:0] DepthCnt  = 4'(DEPTH);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + 1'b1;
  endfunction

  logic [2:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]      count_q, count_d;
  logic            underflow_q, underflow_d;

  logic [3:0] fold_sum;
  logic [2:0] piece;
  logic       valid_sample;
  logic       pop_ok;
  logic       cand;
  logic       accept;

  // 8 == 1 (mod 7), so v mod 7 == (v[5:3] + v[2:0]) mod 7 with sum in 0..14.
  always_comb begin
    fold_sum = {1'b0, rnd_data[5:3]} + {1'b0, rnd_data[2:0]};
    if (fold_sum >= 4'd14) begin
      piece = 3'(fold_sum - 4'd14);
    end else if (fold_sum >= 4'd7) begin
      piece = 3'(fold_sum - 4'd7);
    end else begin
      piece = fold_sum[2:0];
    end
  end

  assign valid_sample = rnd_valid && (rnd_data != 6'd63);
  assign pop_ok       = pop && (count_q != 4'd0);
  // A pop in the same edge frees a slot, so a full queue can still take a sample.
  assign cand         = valid_sample && ((count_q != DepthCnt) || pop_ok);

`ifdef PIECE_NOREPEAT_EN
  logic [2:0] last_piece_q, last_piece_d;
  logic       reroll_used_q, reroll_used_d;
  logic       repeat_hit;

  always_comb begin
    repeat_hit    = cand && (piece == last_piece_q) && !reroll_used_q;
    accept        = cand && !repeat_hit;
    last_piece_d  = last_piece_q;
    reroll_used_d = reroll_used_q;
    if (repeat_hit) begin
      reroll_used_d = 1'b1;
    end else if (accept) begin
      reroll_used_d = 1'b0;
      last_piece_d  = piece;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_piece_q  <= 3'd7;
      reroll_used_q <= 1'b0;
    end else begin
      last_piece_q  <= last_piece_d;
      reroll_used_q <= reroll_used_d;
    end
  end
`else
  assign accept = cand;
`endif

  always_comb begin
    wr_ptr_d    = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    underflow_d = underflow_q || (pop && (count_q == 4'd0));
    count_d     = count_q;
    if (accept && !pop_ok) begin
      count_d = count_q + 4'd1;
    end else if (!accept && pop_ok) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 4'd0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: outputs are masked by the valid flags.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= piece;
    end
  end

  always_comb begin
    head_valid    = (count_q != 4'd0);
    preview_valid = (count_q >= 4'd2);
    head_piece    = head_valid ? mem_q[rd_ptr_q] : 3'd0;
    preview_piece = preview_valid ? mem_q[ptr_inc(rd_ptr_q)] : 3'd0;
    count         = count_q;
    underflow     = underflow_q;
  end

endmodule

// File: tb/tb_piece_queue.sv
// Directed self-checking bench for piece_queue (DEPTH=4); mirrors PIECE_NOREPEAT_EN if defined.
module tb_piece_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] rnd_data;
  logic       rnd_valid;
  logic       pop;
  logic [2:0] head_piece;
  logic       head_valid;
  logic [2:0] preview_piece;
  logic       preview_valid;
  logic [3:0] count;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  piece_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .rnd_data      (rnd_data),
    .rnd_valid     (rnd_valid),
    .pop           (pop),
    .head_piece    (head_piece),
    .head_valid    (head_valid),
    .preview_piece (preview_piece),
    .preview_valid (preview_valid),
    .count         (count),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive for exactly one rising edge; return at the following negedge.
  task automatic cycle(input logic v, input logic [5:0] d, input logic p);
    rnd_valid = v;
    rnd_data  = d;
    pop       = p;
    @(negedge clk);
    rnd_valid = 1'b0;
    pop       = 1'b0;
  endtask

  task automatic push_spaced(input logic [5:0] d);
    cycle(1'b1, d, 1'b0);
    repeat (7) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rnd_valid = 1'b0; rnd_data = '0; pop = 1'b0;
    repeat (2) @(negedge clk);
    cycle(1'b1, 6'd5, 1'b0);  // sample during reset is lost
    check("rst_count", count, 0);
    check("rst_head_valid", head_valid, 0);
    check("rst_head_piece", head_piece, 0);
    check("rst_prev_valid", preview_valid, 0);
    check("rst_prev_piece", preview_piece, 0);
    check("rst_underflow", underflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic mapping and FIFO order
    push_spaced(6'd5);
    push_spaced(6'd62);
    push_spaced(6'd14);
    check("t1_count", count, 3);
    check("t1_head", head_piece, 5);
    check("t1_preview", preview_piece, 6);
    check("t1_prev_valid", preview_valid, 1);
    cycle(1'b0, '0, 1'b1);
    check("t1_pop1_head", head_piece, 6);
    cycle(1'b0, '0, 1'b1);
    check("t1_pop2_head", head_piece, 0);
    check("t1_pop2_count", count, 1);
    check("t1_pop2_prev_valid", preview_valid, 0);
    cycle(1'b0, '0, 1'b1);
    check("t1_empty_count", count, 0);

    // v=63 rejected
    push_spaced(6'd63);
    check("t2_63_head_valid", head_valid, 0);
    check("t2_63_count", count, 0);
    push_spaced(6'd13);
    check("t2_13_head", head_piece, 6);
    check("t2_13_count", count, 1);
    cycle(1'b0, '0, 1'b1);

    // Full behaviour
    cycle(1'b1, 6'd0, 1'b0);
    cycle(1'b1, 6'd1, 1'b0);
    cycle(1'b1, 6'd2, 1'b0);
    cycle(1'b1, 6'd3, 1'b0);
    check("t3_full_count", count, 4);
    cycle(1'b1, 6'd4, 1'b0);
    check("t3_disc_count", count, 4);
    check("t3_disc_head", head_piece, 0);
    cycle(1'b1, 6'd4, 1'b1);
    check("t3_pp_count", count, 4);
    check("t3_pp_head", head_piece, 1);
    check("t3_pp_preview", preview_piece, 2);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("t3_pre_tail_head", head_piece, 3);
    cycle(1'b0, '0, 1'b1);
    check("t3_tail_head", head_piece, 4);
    check("t3_tail_count", count, 1);
    check("t3_underflow_clear", underflow, 0);
    cycle(1'b0, '0, 1'b1);

    // Underflow is sticky
    cycle(1'b0, '0, 1'b1);
    check("t4_uf_count", count, 0);
    check("t4_uf_set", underflow, 1);
    repeat (3) @(negedge clk);
    check("t4_uf_sticky", underflow, 1);

    // Async reset mid-fill
    cycle(1'b1, 6'd1, 1'b0);
    cycle(1'b1, 6'd2, 1'b0);
    check("t5_pre_count", count, 2);
    #1 rst = 1'b1;
    #1;
    check("t5_async_count", count, 0);
    check("t5_async_head_valid", head_valid, 0);
    check("t5_async_head", head_piece, 0);
    check("t5_async_prev_valid", preview_valid, 0);
    check("t5_async_underflow", underflow, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Repeat handling: all three map to piece 3
    push_spaced(6'd3);
    push_spaced(6'd10);
    push_spaced(6'd17);
`ifdef PIECE_NOREPEAT_EN
    check("t6_nr_count", count, 2);
    check("t6_nr_head", head_piece, 3);
    check("t6_nr_preview", preview_piece, 3);
`else
    check("t6_count", count, 3);
    check("t6_head", head_piece, 3);
    check("t6_preview", preview_piece, 3);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("t6_third", head_piece, 3);
    check("t6_third_count", count, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
